// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment type, glyph table, select-width helper.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // A single-digit display still needs a 1-bit select register.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bundle between score/timer logic (master) and the scan controller (slave).
// Carries the per-digit request fields in and the registered pin drives out.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import sevenseg_pkg::*;

  logic                    scan_en;
  logic                    blink_tick;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dps;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  logic                    hex_mode;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    seg;
  logic                    dp;

  modport master (
    output scan_en, blink_tick, digits, dps, digit_en, blink_mask, lz_blank, hex_mode,
    input  an, seg, dp
  );

  modport slave (
    input  scan_en, blink_tick, digits, dps, digit_en, blink_mask, lz_blank, hex_mode,
    output an, seg, dp
  );

endinterface

// File: rtl/sevenseg_encoder.sv
// Combinational 4-bit value to active-low segment pattern.
// Values 10-15 render blank unless hex_mode selects the A-F glyphs.
module sevenseg_encoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if ((value < 4'd10) || hex_mode) begin
      seg = GLYPHS[value];
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed common-anode scanner: dwell/blank counters, leading-zero
// suppression, blink, and registered pin outputs (one clk behind the state).
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                clk,
  input  logic                rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_DIGITS);
  localparam int DW_W  = $clog2(DWELL_TICKS);

  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_TICKS - 1);
  localparam logic [DW_W-1:0]  BLANK_END  = DW_W'(BLANK_TICKS);

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DW_W-1:0]       dwell_q, dwell_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_run;
  logic [3:0]            cur_val;
  seg_t                  enc_seg;
  logic                  lz_suppressed;
  logic                  visible;
  logic [NUM_DIGITS-1:0] one_hot;

  always_comb begin
    sel_d         = sel_q;
    dwell_d       = dwell_q;
    blink_phase_d = blink_phase_q ^ bus.blink_tick;
    if (bus.scan_en) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (bus.digits[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  assign cur_val = bus.digits[{sel_q, 2'b00} +: 4];

  sevenseg_encoder u_enc (
    .value    (cur_val),
    .hex_mode (bus.hex_mode),
    .seg      (enc_seg)
  );

  always_comb begin
    lz_suppressed = bus.lz_blank && (sel_q != '0) && zero_from[sel_q];
    visible = bus.digit_en[sel_q]
            && !(bus.blink_mask[sel_q] && blink_phase_q)
            && !lz_suppressed
            && (dwell_q >= BLANK_END);

    one_hot        = '0;
    one_hot[sel_q] = 1'b1;

    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~one_hot;
      seg_d = enc_seg;
      dp_d  = ~bus.dps[sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q         <= '0;
      dwell_q       <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      sel_q         <= sel_d;
      dwell_q       <= dwell_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomised bench for sevenseg_scan_ctrl against a scan-count reference model.
module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_TICKS (DW),
    .BLANK_TICKS (BT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] glyph_tb [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: total scan pulses since reset and number of blink ticks (mod 2).
  int         n  = 0;
  bit         ph = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  int         checks = 0;
  int         errs   = 0;

  function automatic void predict();
    int         s  = (n / DW) % ND;
    int         d  = n % DW;
    logic [15:0] dg = bus.digits;
    int         v  = int'((dg >> (4 * s)) & 16'hF);
    bit         lz = bus.lz_blank && (s > 0) && ((dg >> (4 * s)) == 16'd0);
    bit         vis;
    vis = !rst && bus.digit_en[s] && !(bus.blink_mask[s] && ph) && !lz && (d >= BT);
    exp_an  = vis ? ~(4'b0001 << s) : 4'hF;
    exp_seg = (vis && (v < 10 || bus.hex_mode)) ? glyph_tb[v] : 7'h7F;
    exp_dp  = vis ? ~bus.dps[s] : 1'b1;
  endfunction

  task automatic cyc(input logic s, input logic b);
    @(negedge clk);
    bus.scan_en    = s;
    bus.blink_tick = b;
    predict();
    @(posedge clk);
    if (rst) begin
      n  = 0;
      ph = 1'b0;
    end else begin
      n  = n + int'(s);
      ph = ph ^ b;
    end
    #1;
  endtask

  task automatic advance_to(input int slot);
    for (int k = 0; k < 64 && (n % (ND * DW)) != slot; k++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.digits = 16'h4321; bus.dps = '0; bus.digit_en = '1; bus.blink_mask = '0;
    bus.lz_blank = 1'b0; bus.hex_mode = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      errs++; $display("FAIL reset_outputs an=%b seg=%b dp=%b want 1111 1111111 1", bus.an, bus.seg, bus.dp);
    end
    checks++;
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    if (bus.an !== 4'hF) begin
      errs++; $display("FAIL reset_first_blank an=%b want 1111", bus.an);
    end
    checks++;
    cyc(1'b0, 1'b0);
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1001111) begin
      errs++; $display("FAIL reset_first_digit an=%b seg=%b want 1110 1001111", bus.an, bus.seg);
    end
    checks++;
  endtask

  task automatic test_scan_order();
    logic [3:0] seen [$];
    logic [3:0] want [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    bus.digits = 16'h4321; bus.digit_en = '1; bus.lz_blank = 1'b0;
    advance_to(0);
    for (int k = 0; k < 90; k++) begin
      cyc(($urandom_range(0, 3) != 0), 1'b0);
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        errs++; $display("FAIL scan_order n=%0d an=%b seg=%b dp=%b want %b %b %b", n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
      checks++;
      if (bus.an != 4'hF && (seen.size() == 0 || seen[$] != bus.an)) seen.push_back(bus.an);
    end
    for (int i = 0; i < 5; i++) begin
      if (i >= seen.size() || seen[i] !== want[i]) begin
        errs++; $display("FAIL scan_sequence idx=%0d got=%b want=%b", i, (i < seen.size()) ? seen[i] : 4'hx, want[i]);
      end
      checks++;
    end
  endtask

  task automatic test_leading_zeros();
    bus.digits = 16'h0070;
    for (int pass = 0; pass < 2; pass++) begin
      bus.lz_blank = (pass == 0);
      for (int k = 0; k < 40; k++) begin
        cyc(1'b1, 1'b0);
        if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
          errs++; $display("FAIL leading_zeros lz=%0d n=%0d an=%b seg=%b want %b %b", pass == 0, n, bus.an, bus.seg, exp_an, exp_seg);
        end
        checks++;
      end
    end
    advance_to(14);
    cyc(1'b0, 1'b0);
    if (bus.an !== 4'b0111 || bus.seg !== 7'b0000001) begin
      errs++; $display("FAIL lz_off_digit3 an=%b seg=%b want 0111 0000001", bus.an, bus.seg);
    end
    checks++;
  endtask

  task automatic test_hex();
    bus.digits = 16'h000A; bus.lz_blank = 1'b0; bus.dps = 4'b0001;
    for (int pass = 0; pass < 2; pass++) begin
      bus.hex_mode = (pass == 1);
      for (int k = 0; k < 40; k++) begin
        cyc(1'b1, 1'b0);
        if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
          errs++; $display("FAIL hex hex_mode=%0d n=%0d an=%b seg=%b dp=%b want %b %b %b", pass, n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
        end
        checks++;
      end
    end
    bus.dps = '0; bus.hex_mode = 1'b0;
  endtask

  task automatic test_blink();
    bus.digits = 16'h4321; bus.blink_mask = 4'b0001;
    for (int t = 0; t < 2; t++) begin
      cyc(1'b1, 1'b1);
      for (int k = 0; k < 40; k++) begin
        cyc(1'b1, 1'b0);
        if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
          errs++; $display("FAIL blink tick=%0d n=%0d an=%b seg=%b dp=%b want %b %b %b", t, n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
        end
        checks++;
      end
    end
    advance_to(ND * DW - 1);
    cyc(1'b1, 1'b1);
    if (dut.sel_q !== 2'd0 || dut.dwell_q !== 2'd0 || dut.blink_phase_q !== ph) begin
      errs++; $display("FAIL blink_wrap sel=%0d dwell=%0d phase=%0d want 0 0 %0d", dut.sel_q, dut.dwell_q, dut.blink_phase_q, ph);
    end
    checks++;
    bus.blink_mask = '0;
  endtask

  task automatic test_mid_reset();
    advance_to(2 * DW + 3);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    if (dut.sel_q !== 2'd0 || dut.dwell_q !== 2'd0 || bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      errs++; $display("FAIL mid_reset sel=%0d dwell=%0d an=%b seg=%b dp=%b want 0 0 1111 1111111 1", dut.sel_q, dut.dwell_q, bus.an, bus.seg, bus.dp);
    end
    checks++;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0);
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        errs++; $display("FAIL after_reset n=%0d an=%b seg=%b want %b %b", n, bus.an, bus.seg, exp_an, exp_seg);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) begin
        for (int d = 0; d < ND; d++) bus.digits[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        bus.dps        = 4'($urandom);
        bus.digit_en   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        bus.blink_mask = 4'($urandom);
        bus.lz_blank   = 1'($urandom);
        bus.hex_mode   = 1'($urandom);
      end
      cyc(1'($urandom), ($urandom_range(0, 15) == 0));
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp} || $countones(~bus.an) > 1) begin
        errs++; $display("FAIL random k=%0d n=%0d an=%b seg=%b dp=%b want %b %b %b", k, n, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
      checks++;
    end
  endtask

  initial begin
    bus.scan_en = 1'b0; bus.blink_tick = 1'b0;
    bus.digits = '0; bus.dps = '0; bus.digit_en = '0; bus.blink_mask = '0;
    bus.lz_blank = 1'b0; bus.hex_mode = 1'b0;
    test_reset();
    test_scan_order();
    test_leading_zeros();
    test_hex();
    test_blink();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
